seq_restoring_divider: RTL
==========================

Name: seq_restoring_divider

Overview:
- Multi-cycle, parametrised restoring divider for the calculator datapath. Produces one quotient bit per clock.
- Supports unsigned or signed (truncating) division, selected per operation.
- Uses a valid/ready handshake on both input and output so it can sit between the operand register stage and the result/display stage.
- Divide-by-zero is flagged with an error bit, not computed.

Parameters:
- WIDTH, 8, operand/result width in bits (legal range 2..32).
- SIGNED_EN, 1, 1 = honour the is_signed input; 0 = is_signed is ignored and all operations are unsigned.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operands valid.
- in_ready  output  1  block can accept operands (high only in IDLE).
- dividend  input  WIDTH  dividend.
- divisor  input  WIDTH  divisor.
- is_signed  input  1  1 = two's-complement operation.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- quotient  output  WIDTH  quotient.
- remainder  output  WIDTH  remainder.
- error  output  1  divide-by-zero flag, valid with out_valid.
- busy  output  1  high in CALC or DONE.

Behaviour:
- Reset, asynchronous, takes effect immediately:
  - State goes to IDLE.
  - in_ready=1, out_valid=0, busy=0, error=0.
  - quotient=0, remainder=0; internal counter and registers cleared.
  - Reset mid-CALC or mid-DONE aborts the operation; no result is ever presented for it.
- State IDLE:
  - in_ready=1.
  - Accept occurs on in_valid && in_ready at a rising edge. Operands and is_signed (forced to 0 when SIGNED_EN=0) are latched.
  - If divisor==0: go to DONE, with error=1, quotient=all ones, remainder=all ones.
  - Otherwise: go to CALC, counter=WIDTH-1, partial remainder=0. The shift register is loaded with |dividend|, and |divisor| is latched.
  - Magnitudes are taken only when signed and the MSB is set; 2^(WIDTH-1) is held unsigned in WIDTH bits.
- State CALC, one iteration per cycle:
  - Shift {partial remainder, shift register} left by 1.
  - Compute trial = partial remainder - |divisor| in WIDTH+1 bits.
  - If trial is negative: restore, i.e. keep the shifted value and shift in quotient bit 0.
  - Otherwise: partial remainder = trial[WIDTH-1:0] and shift in quotient bit 1.
  - Repeat for WIDTH cycles. On the final cycle (counter==0), apply the sign fix-up and go to DONE.
- Sign fix-up (signed operations only):
  - Quotient is negated if the dividend sign differs from the divisor sign.
  - Remainder is negated if the dividend is negative, so the remainder takes the dividend's sign. Result is truncation toward zero.
  - MIN / -1 wraps: quotient=MIN (0x80 at WIDTH=8), remainder=0, error=0.
- State DONE:
  - out_valid=1, in_ready=0.
  - quotient, remainder and error are held stable until out_valid && out_ready.
  - On that handshake, go to IDLE. The next accept can occur no earlier than the following edge; there is no same-cycle turnaround.
- Latency, counted from the accept edge:
  - Normal operation: out_valid rises WIDTH+1 edges after accept.
  - Divide-by-zero: out_valid rises 1 edge after accept.
- Outputs are registered. quotient, remainder and error retain their last values in IDLE.
- in_valid while busy is ignored. Operand inputs may change freely after accept.

Test Plan:
- Unsigned, WIDTH=8: 13 / 4 -> quotient=3, remainder=1, error=0. out_valid is asserted exactly 9 edges after accept.
- Signed: -7 (0xF9) / 2 -> quotient=0xFD (-3), remainder=0xFF (-1). Also 7 / -2 -> quotient=0xFD, remainder=0x01.
- Divide by zero: 100 / 0 -> error=1, quotient=0xFF, remainder=0xFF, out_valid 1 edge after accept. The next operation 255 / 1 (unsigned) -> quotient=255, remainder=0, error=0.
- Signed overflow: -128 (0x80) / -1 (0xFF) -> quotient=0x80, remainder=0x00, error=0. With SIGNED_EN=0 the same operands -> quotient=0x00, remainder=0x80.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid rises -> outputs are stable and in_ready=0 throughout. in_valid pulses during that window are ignored. After the handshake, in_ready rises on the next edge.
- Reset mid-CALC: assert rst at iteration 3 of 200 / 7 -> out_valid=0, in_ready=1, quotient=remainder=0 immediately. The next operation 200 / 7 -> quotient=28, remainder=4.

Source files
------------

// File: rtl/seq_restoring_divider.sv
// seq_restoring_divider
//   Multi-cycle restoring divider for the calculator datapath. One quotient
//   bit is produced per clock. Operations are unsigned or signed (truncating
//   toward zero), chosen per operation through is_signed.
//
//   Ports:
//     clk        rising-edge clock
//     rst        asynchronous active-high reset
//     in_valid   operands valid           in_ready  can accept (IDLE only)
//     dividend   WIDTH-bit dividend       divisor   WIDTH-bit divisor
//     is_signed  1 = two's-complement operation
//     out_valid  result valid (DONE)      out_ready consumer accepts result
//     quotient   WIDTH-bit quotient       remainder WIDTH-bit remainder
//     error      divide-by-zero flag, valid with out_valid
//     busy       high while in CALC or DONE
module seq_restoring_divider #(
  parameter int WIDTH     = 8,
  parameter bit SIGNED_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             is_signed,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             error,
  output logic             busy
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [1:0]       state_reg;
  logic [CW-1:0]    count_reg;
  logic [WIDTH-1:0] prem_reg;     // partial remainder
  logic [WIDTH-1:0] shreg_reg;    // dividend bits out, quotient bits in
  logic [WIDTH-1:0] dvsr_reg;     // |divisor|
  logic             neg_q_reg;
  logic             neg_r_reg;
  logic [WIDTH-1:0] quotient_reg;
  logic [WIDTH-1:0] remainder_reg;
  logic             error_reg;

  // Operand magnitudes. The most negative value negates to itself, which is
  // exactly its magnitude when read as unsigned.
  logic             signed_op;
  logic             dvd_neg;
  logic             dvs_neg;
  logic [WIDTH-1:0] dvd_mag;
  logic [WIDTH-1:0] dvs_mag;

  assign signed_op = SIGNED_EN ? is_signed : 1'b0;
  assign dvd_neg   = signed_op & dividend[WIDTH-1];
  assign dvs_neg   = signed_op & divisor[WIDTH-1];
  assign dvd_mag   = dvd_neg ? (~dividend + ONE) : dividend;
  assign dvs_mag   = dvs_neg ? (~divisor + ONE) : divisor;

  // One restoring iteration. The shifted remainder is WIDTH+1 bits wide; if
  // its top bit is set it is already at least 2^WIDTH and therefore larger
  // than any divisor, so the subtraction always succeeds and the low WIDTH
  // bits of the short subtraction are still the correct new remainder.
  logic             prem_top;
  logic [WIDTH-1:0] prem_sh;
  logic [WIDTH:0]   trial;
  logic             qbit;
  logic [WIDTH-1:0] prem_new;
  logic [WIDTH-1:0] shreg_new;
  logic [WIDTH-1:0] q_fix;
  logic [WIDTH-1:0] r_fix;

  assign prem_top  = prem_reg[WIDTH-1];
  assign prem_sh   = {prem_reg[WIDTH-2:0], shreg_reg[WIDTH-1]};
  assign trial     = {1'b0, prem_sh} - {1'b0, dvsr_reg};
  assign qbit      = prem_top | ~trial[WIDTH];
  assign prem_new  = qbit ? trial[WIDTH-1:0] : prem_sh;
  assign shreg_new = {shreg_reg[WIDTH-2:0], qbit};
  assign q_fix     = neg_q_reg ? (~shreg_new + ONE) : shreg_new;
  assign r_fix     = neg_r_reg ? (~prem_new + ONE) : prem_new;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      count_reg     <= '0;
      prem_reg      <= '0;
      shreg_reg     <= '0;
      dvsr_reg      <= '0;
      neg_q_reg     <= 1'b0;
      neg_r_reg     <= 1'b0;
      quotient_reg  <= '0;
      remainder_reg <= '0;
      error_reg     <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            neg_q_reg <= dvd_neg ^ dvs_neg;
            neg_r_reg <= dvd_neg;
            if (divisor == '0) begin
              quotient_reg  <= '1;
              remainder_reg <= '1;
              error_reg     <= 1'b1;
              state_reg     <= DONE;
            end else begin
              count_reg <= CW'(WIDTH - 1);
              prem_reg  <= '0;
              shreg_reg <= dvd_mag;
              dvsr_reg  <= dvs_mag;
              state_reg <= CALC;
            end
          end
        end
        CALC: begin
          prem_reg  <= prem_new;
          shreg_reg <= shreg_new;
          count_reg <= count_reg - CW'(1);
          if (count_reg == '0) begin
            quotient_reg  <= q_fix;
            remainder_reg <= r_fix;
            error_reg     <= 1'b0;
            state_reg     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_reg == IDLE);
  assign out_valid = (state_reg == DONE);
  assign busy      = (state_reg != IDLE);
  assign quotient  = quotient_reg;
  assign remainder = remainder_reg;
  assign error     = error_reg;

endmodule
